// File: rtl/cpu_pkg.sv
// cpu_pkg: shared miniRV encodings and the hazard shadow-slot type
package cpu_pkg;
    localparam int REG_AW = 5;
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b11;
    localparam logic [1:0] WD_SEL_ALU  = 2'b00;
    localparam logic [1:0] WD_SEL_LOAD = 2'b01;
    localparam logic [1:0] WD_SEL_PC4  = 2'b10;
    localparam logic [1:0] WD_SEL_IMM  = 2'b11;
    typedef struct packed {
        logic              wen;
        logic [REG_AW-1:0] rd;
        logic              is_load;
    } slot_t;
    function automatic logic slot_hit(input slot_t s, input logic [REG_AW-1:0] rs);
        return s.wen && (s.rd == rs);
    endfunction
endpackage

// File: rtl/hazard_fwd_sel.sv
// hazard_fwd_sel: per-operand forwarding priority mux, EX > MEM > WB > RF
module hazard_fwd_sel
    import cpu_pkg::*;
(
    input  logic       m_ex,
    input  logic       m_mem,
    input  logic       m_wb,
    output logic [1:0] sel
);
    assign sel = m_ex ? FWD_EX : m_mem ? FWD_MEM : m_wb ? FWD_WB : FWD_RF;
endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: stall/flush/forward control for the 5-stage miniRV pipeline
// HAZARD_FWD_EN enables operand forwarding; otherwise any in-flight RAW stalls.
module hazard_unit
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_re1,
    input  logic              id_re2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_rf_we,
    input  logic [1:0]        id_wd_sel,
    input  logic              ex_redirect,
    output logic              stall_pc,
    output logic              stall_if_id,
    output logic              flush_if_id,
    output logic              flush_id_ex,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b
);
    slot_t      id_slot, slot_ex, slot_mem, slot_wb;
    logic [2:0] m1, m2;
    logic       load_use, hazard, unused_wb_load;
    logic [1:0] sel_a, sel_b;

    assign id_slot = '{wen: id_rf_we && (id_rd != '0), rd: id_rd, is_load: id_wd_sel == WD_SEL_LOAD};

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_ex  <= '0;
            slot_mem <= '0;
            slot_wb  <= '0;
        end else begin
            slot_ex  <= flush_id_ex ? '0 : id_slot;
            slot_mem <= slot_ex;
            slot_wb  <= slot_mem;
        end
    end

    // match vectors ordered {EX, MEM, WB}
    assign m1 = (id_re1 && id_rs1 != '0) ?
        {slot_hit(slot_ex, id_rs1), slot_hit(slot_mem, id_rs1), slot_hit(slot_wb, id_rs1)} : 3'b000;
    assign m2 = (id_re2 && id_rs2 != '0) ?
        {slot_hit(slot_ex, id_rs2), slot_hit(slot_mem, id_rs2), slot_hit(slot_wb, id_rs2)} : 3'b000;
    assign load_use = slot_ex.is_load && (m1[2] || m2[2]);
    assign unused_wb_load = slot_wb.is_load;

`ifdef HAZARD_FWD_EN
    assign hazard = load_use;
    hazard_fwd_sel u_fwd_a (
        .m_ex  (m1[2] && !slot_ex.is_load),
        .m_mem (m1[1]),
        .m_wb  (m1[0]),
        .sel   (sel_a)
    );
    hazard_fwd_sel u_fwd_b (
        .m_ex  (m2[2] && !slot_ex.is_load),
        .m_mem (m2[1]),
        .m_wb  (m2[0]),
        .sel   (sel_b)
    );
`else
    // RF is not write-through, so a writer still in WB must be waited out
    assign hazard = load_use || (|{m1, m2});
    assign sel_a  = FWD_RF;
    assign sel_b  = FWD_RF;
`endif

    assign flush_if_id = !rst && ex_redirect;
    assign flush_id_ex = !rst && (ex_redirect || hazard);
    assign stall_pc    = !rst && !ex_redirect && hazard;
    assign stall_if_id = stall_pc;
    assign fwd_a       = rst ? FWD_RF : sel_a;
    assign fwd_b       = rst ? FWD_RF : sel_b;
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed self-checking bench for hazard_unit (both HAZARD_FWD_EN builds)
module tb_hazard_unit;
    typedef struct packed {
        logic [4:0] rs1;
        logic       re1;
        logic [4:0] rs2;
        logic       re2;
        logic [4:0] rd;
        logic       we;
        logic [1:0] ws;
        logic       rdr;
    } ins_t;

    localparam ins_t       NOP = '0;
    localparam logic [7:0] S   = 8'hD0;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       id_re1, id_re2, id_rf_we, ex_redirect;
    logic [1:0] id_wd_sel;
    logic       stall_pc, stall_if_id, flush_if_id, flush_id_ex;
    logic [1:0] fwd_a, fwd_b;
    logic [7:0] outv;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    hazard_unit dut (
        .clk         (clk),
        .rst         (rst),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_re1      (id_re1),
        .id_re2      (id_re2),
        .id_rd       (id_rd),
        .id_rf_we    (id_rf_we),
        .id_wd_sel   (id_wd_sel),
        .ex_redirect (ex_redirect),
        .stall_pc    (stall_pc),
        .stall_if_id (stall_if_id),
        .flush_if_id (flush_if_id),
        .flush_id_ex (flush_id_ex),
        .fwd_a       (fwd_a),
        .fwd_b       (fwd_b)
    );

    assign outv = {stall_pc, stall_if_id, flush_if_id, flush_id_ex, fwd_a, fwd_b};

    function automatic ins_t add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return '{rs1: rs1, re1: 1'b1, rs2: rs2, re2: 1'b1, rd: rd, we: 1'b1, ws: 2'b00, rdr: 1'b0};
    endfunction

    function automatic ins_t lw(input logic [4:0] rd, input logic [4:0] rs1);
        return '{rs1: rs1, re1: 1'b1, rs2: 5'd0, re2: 1'b0, rd: rd, we: 1'b1, ws: 2'b01, rdr: 1'b0};
    endfunction

    task automatic apply(input ins_t i);
        {id_rs1, id_re1, id_rs2, id_re2, id_rd, id_rf_we, id_wd_sel, ex_redirect} = i;
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic drain;
        apply(NOP);
        repeat (3) next_cycle();
    endtask

    task automatic test_reset;
        ins_t i;
        rst = 1'b1;
        i = add(5'd5, 5'd1, 5'd2);
        i.rdr = 1'b1;
        apply(i);
        next_cycle();
        next_cycle();
        @(negedge clk);
        checks++;
        if (outv !== 8'h00) begin
            errors++;
            $display("FAIL reset_hold: got %h want %h", outv, 8'h00);
        end
        next_cycle();
        apply(add(5'd6, 5'd5, 5'd5));
        @(negedge clk);
        checks++;
        if (outv !== 8'h00) begin
            errors++;
            $display("FAIL reset_dep: got %h want %h", outv, 8'h00);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (outv !== 8'h00) begin
            errors++;
            $display("FAIL reset_release: got %h want %h", outv, 8'h00);
        end
        next_cycle();
        drain();
    endtask

    task automatic test_raw;
`ifdef HAZARD_FWD_EN
        ins_t seq [3];
        logic [7:0] exp [3];
        seq = '{add(5'd5, 5'd1, 5'd2), add(5'd6, 5'd5, 5'd3), NOP};
        exp = '{8'h00, 8'h04, 8'h00};
`else
        ins_t seq [6];
        logic [7:0] exp [6];
        seq = '{add(5'd5, 5'd1, 5'd2), add(5'd6, 5'd5, 5'd3), add(5'd6, 5'd5, 5'd3),
                add(5'd6, 5'd5, 5'd3), add(5'd6, 5'd5, 5'd3), NOP};
        exp = '{8'h00, S, S, S, 8'h00, 8'h00};
`endif
        for (int k = 0; k < $size(seq); k++) begin
            apply(seq[k]);
            @(negedge clk);
            checks++;
            if (outv !== exp[k]) begin
                errors++;
                $display("FAIL raw[%0d]: got %h want %h", k, outv, exp[k]);
            end
            next_cycle();
        end
        drain();
    endtask

    task automatic test_mem_wb;
`ifdef HAZARD_FWD_EN
        ins_t seq [4];
        logic [7:0] exp [4];
        seq = '{add(5'd5, 5'd1, 5'd2), add(5'd7, 5'd1, 5'd2), add(5'd8, 5'd7, 5'd5), add(5'd9, 5'd5, 5'd8)};
        exp = '{8'h00, 8'h00, 8'h06, 8'h0D};
`else
        ins_t seq [10];
        logic [7:0] exp [10];
        seq = '{add(5'd5, 5'd1, 5'd2), add(5'd7, 5'd1, 5'd2),
                add(5'd8, 5'd7, 5'd5), add(5'd8, 5'd7, 5'd5), add(5'd8, 5'd7, 5'd5), add(5'd8, 5'd7, 5'd5),
                add(5'd9, 5'd5, 5'd8), add(5'd9, 5'd5, 5'd8), add(5'd9, 5'd5, 5'd8), add(5'd9, 5'd5, 5'd8)};
        exp = '{8'h00, 8'h00, S, S, S, 8'h00, S, S, S, 8'h00};
`endif
        for (int k = 0; k < $size(seq); k++) begin
            apply(seq[k]);
            @(negedge clk);
            checks++;
            if (outv !== exp[k]) begin
                errors++;
                $display("FAIL mem_wb[%0d]: got %h want %h", k, outv, exp[k]);
            end
            next_cycle();
        end
        drain();
    endtask

    task automatic test_priority;
`ifdef HAZARD_FWD_EN
        ins_t seq [4];
        logic [7:0] exp [4];
        seq = '{add(5'd5, 5'd1, 5'd2), add(5'd5, 5'd3, 5'd4), add(5'd6, 5'd5, 5'd5), NOP};
        exp = '{8'h00, 8'h00, 8'h05, 8'h00};
`else
        ins_t seq [7];
        logic [7:0] exp [7];
        seq = '{add(5'd5, 5'd1, 5'd2), add(5'd5, 5'd3, 5'd4), add(5'd6, 5'd5, 5'd5),
                add(5'd6, 5'd5, 5'd5), add(5'd6, 5'd5, 5'd5), add(5'd6, 5'd5, 5'd5), NOP};
        exp = '{8'h00, 8'h00, S, S, S, 8'h00, 8'h00};
`endif
        for (int k = 0; k < $size(seq); k++) begin
            apply(seq[k]);
            @(negedge clk);
            checks++;
            if (outv !== exp[k]) begin
                errors++;
                $display("FAIL priority[%0d]: got %h want %h", k, outv, exp[k]);
            end
            next_cycle();
        end
        drain();
    endtask

    task automatic test_load_use;
`ifdef HAZARD_FWD_EN
        ins_t seq [4];
        logic [7:0] exp [4];
        seq = '{lw(5'd5, 5'd1), add(5'd6, 5'd5, 5'd5), add(5'd6, 5'd5, 5'd5), NOP};
        exp = '{8'h00, S, 8'h0A, 8'h00};
`else
        ins_t seq [6];
        logic [7:0] exp [6];
        seq = '{lw(5'd5, 5'd1), add(5'd6, 5'd5, 5'd5), add(5'd6, 5'd5, 5'd5),
                add(5'd6, 5'd5, 5'd5), add(5'd6, 5'd5, 5'd5), NOP};
        exp = '{8'h00, S, S, S, 8'h00, 8'h00};
`endif
        for (int k = 0; k < $size(seq); k++) begin
            apply(seq[k]);
            @(negedge clk);
            checks++;
            if (outv !== exp[k]) begin
                errors++;
                $display("FAIL load_use[%0d]: got %h want %h", k, outv, exp[k]);
            end
            next_cycle();
        end
        drain();
    endtask

    task automatic test_back_to_back;
`ifdef HAZARD_FWD_EN
        ins_t seq [6];
        logic [7:0] exp [6];
        seq = '{lw(5'd5, 5'd1), lw(5'd6, 5'd5), lw(5'd6, 5'd5),
                add(5'd7, 5'd6, 5'd1), add(5'd7, 5'd6, 5'd1), NOP};
        exp = '{8'h00, S, 8'h08, S, 8'h08, 8'h00};
`else
        ins_t seq [10];
        logic [7:0] exp [10];
        seq = '{lw(5'd5, 5'd1), lw(5'd6, 5'd5), lw(5'd6, 5'd5), lw(5'd6, 5'd5), lw(5'd6, 5'd5),
                add(5'd7, 5'd6, 5'd1), add(5'd7, 5'd6, 5'd1), add(5'd7, 5'd6, 5'd1), add(5'd7, 5'd6, 5'd1), NOP};
        exp = '{8'h00, S, S, S, 8'h00, S, S, S, 8'h00, 8'h00};
`endif
        for (int k = 0; k < $size(seq); k++) begin
            apply(seq[k]);
            @(negedge clk);
            checks++;
            if (outv !== exp[k]) begin
                errors++;
                $display("FAIL b2b[%0d]: got %h want %h", k, outv, exp[k]);
            end
            next_cycle();
        end
        drain();
    endtask

    task automatic test_redirect;
        ins_t seq [5];
        logic [7:0] exp [5];
        ins_t a6, a9;
        a6 = add(5'd6, 5'd5, 5'd5);
        a6.rdr = 1'b1;
        a9 = add(5'd9, 5'd1, 5'd2);
        a9.rdr = 1'b1;
        seq = '{lw(5'd5, 5'd1), a6, add(5'd7, 5'd6, 5'd1), a9, NOP};
        exp = '{8'h00, 8'h30, 8'h00, 8'h30, 8'h00};
        for (int k = 0; k < $size(seq); k++) begin
            apply(seq[k]);
            @(negedge clk);
            checks++;
            if (outv !== exp[k]) begin
                errors++;
                $display("FAIL redirect[%0d]: got %h want %h", k, outv, exp[k]);
            end
            next_cycle();
        end
        drain();
    endtask

    task automatic test_x0;
        ins_t seq [5];
        ins_t st, rd_off;
        st = add(5'd5, 5'd1, 5'd2);
        st.we = 1'b0;
        rd_off = add(5'd9, 5'd7, 5'd0);
        rd_off.re1 = 1'b0;
        rd_off.re2 = 1'b0;
        seq = '{add(5'd0, 5'd0, 5'd0), add(5'd7, 5'd0, 5'd0), st, add(5'd8, 5'd5, 5'd5), rd_off};
        seq[0].re2 = 1'b0;
        for (int k = 0; k < $size(seq); k++) begin
            apply(seq[k]);
            @(negedge clk);
            checks++;
            if (outv !== 8'h00) begin
                errors++;
                $display("FAIL x0[%0d]: got %h want %h", k, outv, 8'h00);
            end
            next_cycle();
        end
        drain();
    endtask

    task automatic test_reset_mid_stall;
        apply(lw(5'd5, 5'd1));
        @(negedge clk);
        checks++;
        if (outv !== 8'h00) begin
            errors++;
            $display("FAIL rst_mid_load: got %h want %h", outv, 8'h00);
        end
        next_cycle();
        apply(add(5'd6, 5'd5, 5'd5));
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (outv !== 8'h00) begin
            errors++;
            $display("FAIL rst_mid_forced: got %h want %h", outv, 8'h00);
        end
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (outv !== 8'h00) begin
            errors++;
            $display("FAIL rst_mid_after: got %h want %h", outv, 8'h00);
        end
        next_cycle();
        drain();
    endtask

    initial begin
        apply(NOP);
        test_reset();
        test_raw();
        test_mem_wb();
        test_priority();
        test_load_use();
        test_back_to_back();
        test_redirect();
        test_x0();
        test_reset_mid_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end
endmodule
